// File: rtl/mopshub_seq_pkg.sv
// Shared state encoding, phase indices and phase-order helpers for the MOPSHUB bus self-test sequencer.
package mopshub_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_PH_RX,
        ST_RX_EW,
        ST_GAP,
        ST_PH_TX,
        ST_PH_ADV,
        ST_NEXT,
        ST_FIN
    } seq_state_t;

    localparam logic [1:0] PH_RX   = 2'd0;
    localparam logic [1:0] PH_TX   = 2'd1;
    localparam logic [1:0] PH_ADV  = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    // cur == PH_NONE asks for the first enabled phase of a bus.
    function automatic logic [1:0] next_phase(input logic [2:0] en, input logic [1:0] cur);
        logic [1:0] nxt;
        nxt = PH_NONE;
        for (int i = 2; i >= 0; i--) begin
            if (en[i] && (cur == PH_NONE || i > int'(cur))) nxt = 2'(i);
        end
        return nxt;
    endfunction

    function automatic seq_state_t phase_state(input logic [1:0] ph);
        case (ph)
            PH_RX:   return ST_PH_RX;
            PH_TX:   return ST_PH_TX;
            PH_ADV:  return ST_PH_ADV;
            default: return ST_NEXT;
        endcase
    endfunction

endpackage

// File: rtl/mopshub_seq_timer.sv
// Loadable down-counter that stops at zero; shared by phase timeout and RX->TX gap timing.
module mopshub_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mopshub_bus_test_seq.sv
// Per-bus self-test sequencer: walks buses 0..n_buses through enabled RX/TX/ADVANCED phases.
// Optional MOPSHUB_SEQ_RETRY_EN: a timed-out phase is re-issued once before a fail is recorded.
module mopshub_bus_test_seq
    import mopshub_seq_pkg::*;
#(
    parameter int N_BUS   = 32,
    parameter int BUS_W   = 5,
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 40000,
    parameter int GAP_CYC = 120
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [BUS_W-1:0] n_buses,
    input  logic [2:0]       phase_en,
    input  logic             test_rx_end,
    input  logic             test_tx_end,
    input  logic             test_advanced_end,
    output logic             test_rx,
    output logic             test_tx,
    output logic             test_advanced,
    output logic [BUS_W-1:0] bus_sel,
    output logic             endwait_all,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [N_BUS-1:0] pass_map,
    output logic [N_BUS-1:0] fail_map,
    output logic [7:0]       tmo_cnt
);

    seq_state_t       r_state, w_state_nxt;
    logic [2:0]       r_en;
    logic [BUS_W-1:0] r_bus_sel, w_last_bus;
    logic [N_BUS-1:0] r_pass_map, r_fail_map, w_bus_mask;
    logic [7:0]       r_tmo_cnt;
    logic             r_aborted;
    logic             w_start, w_abort, w_in_phase, w_act_end, w_expire;
    logic             w_retry, w_rec_fail, w_exit, w_hold;
    logic             w_tmr_load, w_tmr_zero;
    logic [TMO_W-1:0] w_tmr_val;

`ifdef MOPSHUB_SEQ_RETRY_EN
    logic r_retried, r_hold;
    assign w_hold  = r_hold;
    assign w_retry = w_expire && !r_retried;
`else
    assign w_hold  = 1'b0;
    assign w_retry = 1'b0;
`endif

    assign w_last_bus = (int'(n_buses) >= N_BUS) ? BUS_W'(N_BUS - 1) : n_buses;
    assign w_bus_mask = N_BUS'(1) << r_bus_sel;

    assign w_start    = start && (r_state == ST_IDLE);
    assign w_abort    = abort && (r_state != ST_IDLE);
    assign w_in_phase = (r_state == ST_PH_RX) || (r_state == ST_PH_TX) || (r_state == ST_PH_ADV);
    assign w_act_end  = !w_hold && ((r_state == ST_PH_RX  && test_rx_end) ||
                                    (r_state == ST_PH_TX  && test_tx_end) ||
                                    (r_state == ST_PH_ADV && test_advanced_end));
    // An end pulse in the expiry cycle wins over the timeout.
    assign w_expire   = w_in_phase && !w_hold && w_tmr_zero && !w_act_end;
    assign w_rec_fail = w_expire && !w_retry;
    assign w_exit     = w_act_end || w_rec_fail;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_state_nxt = ST_LAUNCH;
            ST_LAUNCH: w_state_nxt = (r_en == 3'b000) ? ST_FIN : phase_state(next_phase(r_en, PH_NONE));
            ST_PH_RX:  if (w_exit) w_state_nxt = ST_RX_EW;
            ST_RX_EW:  w_state_nxt = r_en[PH_TX] ? ST_GAP : phase_state(next_phase(r_en, PH_RX));
            ST_GAP:    if (w_tmr_zero) w_state_nxt = ST_PH_TX;
            ST_PH_TX:  if (w_exit) w_state_nxt = phase_state(next_phase(r_en, PH_TX));
            ST_PH_ADV: if (w_exit) w_state_nxt = ST_NEXT;
            ST_NEXT:   w_state_nxt = (r_bus_sel == w_last_bus) ? ST_FIN
                                                               : phase_state(next_phase(r_en, PH_NONE));
            ST_FIN:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) w_state_nxt = ST_IDLE;
    end

    // Reload on entry to any timed state, and during the retry low cycle.
    assign w_tmr_load = ((w_state_nxt != r_state) &&
                         (w_state_nxt inside {ST_PH_RX, ST_PH_TX, ST_PH_ADV, ST_GAP})) || w_hold;
    assign w_tmr_val  = (w_state_nxt == ST_GAP) ? TMO_W'(GAP_CYC - 1) : TMO_W'(TMO_CYC - 1);

    mopshub_seq_timer #(.W(TMO_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (r_state != ST_IDLE),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_en       <= '0;
            r_bus_sel  <= '0;
            r_pass_map <= '0;
            r_fail_map <= '0;
            r_tmo_cnt  <= '0;
            r_aborted  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_abort) begin
                r_aborted <= 1'b1;
            end else if (w_start) begin
                r_aborted  <= 1'b0;
                r_en       <= phase_en;
                r_bus_sel  <= '0;
                r_pass_map <= '0;
                r_fail_map <= '0;
                r_tmo_cnt  <= '0;
            end else begin
                if (w_rec_fail) r_fail_map <= r_fail_map | w_bus_mask;
                if (w_expire && r_tmo_cnt != 8'hFF) r_tmo_cnt <= r_tmo_cnt + 8'd1;
                if (r_state == ST_NEXT) begin
                    if ((r_fail_map & w_bus_mask) == '0) r_pass_map <= r_pass_map | w_bus_mask;
                    if (r_bus_sel != w_last_bus) r_bus_sel <= r_bus_sel + 1'b1;
                end
            end
        end
    end

`ifdef MOPSHUB_SEQ_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retried <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_hold <= w_retry && !w_abort;
            if (w_state_nxt != r_state) r_retried <= 1'b0;
            else if (w_retry)           r_retried <= 1'b1;
        end
    end
`endif

    assign test_rx       = (r_state == ST_PH_RX)  && !w_hold;
    assign test_tx       = (r_state == ST_PH_TX)  && !w_hold;
    assign test_advanced = (r_state == ST_PH_ADV) && !w_hold;
    assign endwait_all   = (r_state == ST_RX_EW);
    assign busy          = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign done          = (r_state == ST_FIN) && !abort;
    assign bus_sel       = r_bus_sel;
    assign aborted       = r_aborted;
    assign pass_map      = r_pass_map;
    assign fail_map      = r_fail_map;
    assign tmo_cnt       = r_tmo_cnt;

endmodule
